// File: rtl/bin_div_if.sv
// bin_div_if: start/busy/done handshake and operand/result bus for the restoring divider.
interface bin_div_if #(parameter int WIDTH = 32);
    logic               start;
    logic [2*WIDTH-1:0] N;
    logic [WIDTH-1:0]   D;
    logic [WIDTH-1:0]   Q;
    logic [WIDTH-1:0]   R;
    logic               busy;
    logic               done;
    logic               div_by_zero;
    logic               overflow;

    modport master (output start, N, D, input Q, R, busy, done, div_by_zero, overflow);
    modport slave  (input start, N, D, output Q, R, busy, done, div_by_zero, overflow);
endinterface

// File: rtl/bin_div.sv
// bin_div: radix-2 restoring divider, 2*WIDTH-bit dividend by WIDTH-bit divisor, one quotient bit per clock.
module bin_div #(
    parameter int WIDTH = 32
) (
    input logic       CLK,
    input logic       rst_n,
    bin_div_if.slave  bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, ERR, DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] rem_q, quo_q, d_q, q_q, r_q;
    logic [WIDTH-1:0] rem_d, quo_d;
    logic [CW-1:0]    cnt_q;
    logic             busy_q, done_q, dz_q, ov_q;
    logic [WIDTH:0]   t;
    logic             ge, accept, bad;

    // rem < D holds throughout RUN, so a WIDTH+1-bit compare never loses a quotient bit
    always_comb begin
        t      = {rem_q, quo_q[WIDTH-1]};
        ge     = t >= {1'b0, d_q};
        rem_d  = ge ? WIDTH'(t - {1'b0, d_q}) : t[WIDTH-1:0];
        quo_d  = (quo_q << 1) | WIDTH'(ge);
        accept = bus.start && (state_q == IDLE || state_q == DONE);
        bad    = bus.N[2*WIDTH-1:WIDTH] >= bus.D;
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
            quo_q   <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                d_q     <= bus.D;
                rem_q   <= bus.N[2*WIDTH-1:WIDTH];
                quo_q   <= bus.N[WIDTH-1:0];
                cnt_q   <= '0;
                state_q <= bad ? ERR : RUN;
                busy_q  <= !bad;
            end else if (state_q == RUN) begin
                rem_q <= rem_d;
                quo_q <= quo_d;
                cnt_q <= cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_q <= DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    q_q     <= quo_d;
                    r_q     <= rem_d;
                    dz_q    <= 1'b0;
                    ov_q    <= 1'b0;
                end
            end else if (state_q == ERR) begin
                // quo_q still holds the low dividend half, which is the error-case remainder
                state_q <= DONE;
                done_q  <= 1'b1;
                q_q     <= '1;
                r_q     <= quo_q;
                dz_q    <= d_q == '0;
                ov_q    <= d_q != '0;
            end else if (state_q == DONE) begin
                state_q <= IDLE;
            end
        end
    end

    assign bus.Q           = q_q;
    assign bus.R           = r_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dz_q;
    assign bus.overflow    = ov_q;
endmodule

// File: tb/tb_bin_div.sv
// tb_bin_div: directed and round-trip checks of the bin_div restoring divider.
module tb_bin_div;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    bin_div_if #(.WIDTH(32)) bus ();
    bin_div #(.WIDTH(32)) dut (.CLK(clk), .rst_n(rst_n), .bus(bus));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Called at a negedge; start is presented for one edge, results checked when done is seen.
    task automatic div(input string tag, input logic [63:0] n, input logic [31:0] d,
                       input logic [31:0] eq, input logic [31:0] er, input logic edz,
                       input logic eov, input int elat, input int poke);
        int cyc = 0;
        bus.start = 1'b1;
        bus.N = n;
        bus.D = d;
        @(negedge clk);
        bus.start = 1'b0;
        chk({tag, " busy"}, 64'(bus.busy), 64'(elat > 1));
        while (!bus.done && cyc < 100) begin
            if (poke >= 0) begin
                bus.start = (cyc == poke);
                bus.N = {$urandom, $urandom};
                bus.D = $urandom;
            end
            @(negedge clk);
            cyc++;
        end
        bus.start = 1'b0;
        chk({tag, " lat"}, 64'(cyc), 64'(elat));
        chk({tag, " Q"}, 64'(bus.Q), 64'(eq));
        chk({tag, " R"}, 64'(bus.R), 64'(er));
        chk({tag, " dz"}, 64'(bus.div_by_zero), 64'(edz));
        chk({tag, " ov"}, 64'(bus.overflow), 64'(eov));
    endtask

    initial begin
        logic [31:0] a, b, hi;
        logic [63:0] n;
        bus.start = 1'b0;
        bus.N = '0;
        bus.D = '0;
        repeat (2) @(negedge clk);
        chk("rst Q", 64'(bus.Q), 64'd0);
        chk("rst R", 64'(bus.R), 64'd0);
        chk("rst busy", 64'(bus.busy), 64'd0);
        chk("rst done", 64'(bus.done), 64'd0);
        chk("rst dz", 64'(bus.div_by_zero), 64'd0);
        chk("rst ov", 64'(bus.overflow), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        div("100/7", 64'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 32, -1);
        @(negedge clk);
        chk("pulse done", 64'(bus.done), 64'd0);
        chk("hold Q", 64'(bus.Q), 64'd14);
        div("maxsq", 64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, 32, -1);
        @(negedge clk);
        div("div1", 64'h0000_0000_FFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, 32, -1);
        @(negedge clk);
        div("dz", 64'h1234, 32'd0, 32'hFFFF_FFFF, 32'h1234, 1'b1, 1'b0, 1, -1);
        @(negedge clk);
        div("ov", 64'h1_0000_0000, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1, 1, -1);
        div("b2b", 64'd50, 32'd5, 32'd10, 32'd0, 1'b0, 1'b0, 32, -1);
        @(negedge clk);
        div("ign", 64'd1000, 32'd10, 32'd100, 32'd0, 1'b0, 1'b0, 32, 10);
        @(negedge clk);
        bus.start = 1'b1;
        bus.N = 64'd100;
        bus.D = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid rst Q", 64'(bus.Q), 64'd0);
        chk("mid rst R", 64'(bus.R), 64'd0);
        chk("mid rst busy", 64'(bus.busy), 64'd0);
        chk("mid rst done", 64'(bus.done), 64'd0);
        repeat (40) @(negedge clk);
        chk("rst no done", 64'(bus.done), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        div("rerun", 64'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 32, -1);
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            a = $urandom;
            b = $urandom;
            if (b == 0) b = 32'd1;
            div("rt", {32'd0, a} * {32'd0, b}, b, a, 32'd0, 1'b0, 1'b0, 32, -1);
        end
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            b = $urandom;
            if (b == 0) b = 32'd1;
            hi = $urandom % b;
            n = {hi, 32'($urandom)};
            div("rnd", n, b, 32'(n / {32'd0, b}), 32'(n % {32'd0, b}), 1'b0, 1'b0, 32, -1);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
